instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 14 +
 rtl/instr_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Program-memory read bus between the fetch unit (master) and instruction memory (slave).
// The read request is held until the memory returns data with mem_rdy.
interface instr_fetch_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_rdy;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (output mem_addr, output mem_rd, input mem_rdy, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_rdy, output mem_data);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch FSM (IDLE/READ/LOAD): fetch_go to LOAD in 2 cycles minimum; waits on mem_rdy.
// Optional FETCH_TIMEOUT_EN macro adds a 4-bit READ-wait watchdog with a sticky fault flag.
module instr_fetch #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_go,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  flush,
  instr_fetch_if.master         mem,
  output logic [DATA_WIDTH-1:0] busC,
  output logic                  ir_ena,
  output logic                  ir_sclr,
  output logic                  fetch_done,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  fault
);

  typedef enum logic [1:0] {IDLE, READ, LOAD} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  rd_q, rd_nxt;
  logic [DATA_WIDTH-1:0] busc_q, busc_nxt;
  logic                  ena_q, ena_nxt;
  logic                  sclr_q, sclr_nxt;
  logic                  done_q, done_nxt;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       fault_q, fault_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      addr_q <= '0;
      rd_q   <= 1'b0;
      busc_q <= '0;
      ena_q  <= 1'b0;
      sclr_q <= 1'b0;
      done_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      addr_q <= addr_nxt;
      rd_q   <= rd_nxt;
      busc_q <= busc_nxt;
      ena_q  <= ena_nxt;
      sclr_q <= sclr_nxt;
      done_q <= done_nxt;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt <= wait_cnt_nxt;
      fault_q  <= fault_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    addr_nxt  = addr_q;
    rd_nxt    = rd_q;
    busc_nxt  = busc_q;
    ena_nxt   = 1'b0;
    sclr_nxt  = 1'b0;
    done_nxt  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
    fault_nxt    = fault_q;
`endif
    if (flush) begin
      // Abort whatever is in flight and clear the IR; pc is left untouched.
      state_nxt = IDLE;
      rd_nxt    = 1'b0;
      busc_nxt  = '0;
      ena_nxt   = 1'b1;
      sclr_nxt  = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      fault_nxt = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (jump) pc_nxt = jump_addr;
          if (fetch_go) begin
            addr_nxt  = jump ? jump_addr : pc_q;
            rd_nxt    = 1'b1;
            state_nxt = READ;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_nxt = '0;
`endif
          end
        end
        READ: begin
          if (mem.mem_rdy) begin
            busc_nxt  = mem.mem_data;
            rd_nxt    = 1'b0;
            ena_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = LOAD;
`ifdef FETCH_TIMEOUT_EN
          end else if (wait_cnt == 4'd14) begin
            // Fifteenth unanswered cycle: give up and clear the IR.
            wait_cnt_nxt = 4'd15;
            rd_nxt       = 1'b0;
            busc_nxt     = '0;
            ena_nxt      = 1'b1;
            sclr_nxt     = 1'b1;
            fault_nxt    = 1'b1;
            state_nxt    = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + 4'd1;
`endif
          end
        end
        LOAD: begin
          pc_nxt    = pc_q + 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_rd   = rd_q;
  assign busC         = busc_q;
  assign ir_ena       = ena_q;
  assign ir_sclr      = sclr_q;
  assign fetch_done   = done_q;
  assign pc           = pc_q;
  assign busy         = (state != IDLE);
`ifdef FETCH_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; inputs change 1ns after posedge, outputs sampled there too.
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_go;
  logic       jump;
  logic [7:0] jump_addr;
  logic       flush;
  logic [7:0] busC;
  logic       ir_ena;
  logic       ir_sclr;
  logic       fetch_done;
  logic [7:0] pc;
  logic       busy;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) mem ();

  instr_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_go   (fetch_go),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .flush      (flush),
    .mem        (mem.master),
    .busC       (busC),
    .ir_ena     (ir_ena),
    .ir_sclr    (ir_sclr),
    .fetch_done (fetch_done),
    .pc         (pc),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_go = 1'b0; jump = 1'b0; jump_addr = 8'h00; flush = 1'b0;
    mem.mem_rdy = 1'b0; mem.mem_data = 8'h00;
    step(); step();
    check("rst_pc", pc, 8'h00);
    check("rst_addr", mem.mem_addr, 8'h00);
    check("rst_rd", mem.mem_rd, 1'b0);
    check("rst_busC", busC, 8'h00);
    check("rst_ctl", {ir_ena, ir_sclr, fetch_done, busy, fault}, 5'b0);
    rst = 1'b0;

    // Minimum-latency fetch of 0xA5 from address 0.
    fetch_go = 1'b1;
    step();
    check("f1_rd", mem.mem_rd, 1'b1);
    check("f1_addr", mem.mem_addr, 8'h00);
    check("f1_busy", busy, 1'b1);
    fetch_go = 1'b0; mem.mem_rdy = 1'b1; mem.mem_data = 8'hA5;
    step();
    mem.mem_rdy = 1'b0;
    check("f1_busC", busC, 8'hA5);
    check("f1_load", {ir_ena, fetch_done, ir_sclr, mem.mem_rd}, 4'b1100);
    step();
    check("f1_pulse_end", {ir_ena, fetch_done, busy}, 3'b000);
    check("f1_pc", pc, 8'h01);
    check("f1_busC_hold", busC, 8'hA5);

    // Jump+fetch to 0x40; memory answers on the 4th READ cycle; jump/fetch_go ignored while busy.
    jump = 1'b1; jump_addr = 8'h40; fetch_go = 1'b1;
    step();
    check("j_pc", pc, 8'h40);
    jump_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("j_addr%0d", i), mem.mem_addr, 8'h40);
      check($sformatf("j_rd%0d", i), mem.mem_rd, 1'b1);
      if (i == 3) begin
        jump = 1'b0; fetch_go = 1'b0; mem.mem_rdy = 1'b1; mem.mem_data = 8'h3C;
      end
      step();
    end
    mem.mem_rdy = 1'b0;
    check("j_busC", busC, 8'h3C);
    check("j_done", fetch_done, 1'b1);
    check("j_pc_ignored_jump", pc, 8'h40);
    step();
    check("j_pc_final", pc, 8'h41);

    // pc wrap from 0xFF.
    jump = 1'b1; jump_addr = 8'hFF;
    step();
    jump = 1'b0;
    check("w_pc", pc, 8'hFF);
    check("w_idle", {busy, mem.mem_rd}, 2'b00);
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0; mem.mem_rdy = 1'b1; mem.mem_data = 8'h11;
    step();
    mem.mem_rdy = 1'b0;
    step();
    check("w_pc_wrap", pc, 8'h00);

    // Flush in READ beats a simultaneous mem_rdy.
    jump = 1'b1; jump_addr = 8'h30; fetch_go = 1'b1;
    step();
    jump = 1'b0; fetch_go = 1'b0; flush = 1'b1; mem.mem_rdy = 1'b1; mem.mem_data = 8'h77;
    step();
    flush = 1'b0; mem.mem_rdy = 1'b0;
    check("fl_ctl", {ir_sclr, ir_ena, fetch_done, mem.mem_rd, busy}, 5'b11000);
    check("fl_busC", busC, 8'h00);
    check("fl_pc", pc, 8'h30);
    step();
    check("fl_pulse_end", {ir_sclr, ir_ena, fetch_done}, 3'b000);
    check("fl_pc_hold", pc, 8'h30);

    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    // Timeout: 15 unanswered READ cycles then abort with sticky fault.
    for (int i = 0; i < 14; i++) step();
    check("to_still_rd", mem.mem_rd, 1'b1);
    step();
    check("to_abort", {mem.mem_rd, ir_sclr, ir_ena, busy, fault}, 5'b01101);
    check("to_busC", busC, 8'h00);
    check("to_pc", pc, 8'h30);
    step(); step();
    check("to_sticky", fault, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("to_clear", fault, 1'b0);
`else
    // Without the watchdog READ waits indefinitely.
    for (int i = 0; i < 20; i++) step();
    check("nt_wait", {mem.mem_rd, busy, fault}, 3'b110);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("nt_flush", {mem.mem_rd, busy}, 2'b00);
`endif

    // Reset mid-READ, then a late mem_rdy must be ignored.
    jump = 1'b1; jump_addr = 8'h22; fetch_go = 1'b1;
    step();
    jump = 1'b0; fetch_go = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; mem.mem_rdy = 1'b1; mem.mem_data = 8'h99;
    step();
    mem.mem_rdy = 1'b0;
    check("r_ctl", {ir_ena, ir_sclr, fetch_done, mem.mem_rd, busy, fault}, 6'b0);
    check("r_busC", busC, 8'h00);
    check("r_pc", pc, 8'h00);
    check("r_addr", mem.mem_addr, 8'h00);
    step();
    check("r_no_load", {ir_ena, fetch_done}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
